// File: rtl/piso_tx_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | piso_tx_if : parallel-in request / serial-out status bundle for piso_tx |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i;
  logic             load;
  logic             so;
  logic             busy;
  logic             done;

  modport master (output i, load, input so, busy, done);
  modport slave  (input i, load, output so, busy, done);
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | piso_tx : UART-style serializer, start/data LSB-first/stop framing.    |
// |           Define PISO_TX_PARITY_EN to add an even-parity bit.           |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
module piso_tx #(
  parameter int WIDTH    = 4,
  parameter int BAUD_DIV = 1
) (
  input  wire logic  clk,
  input  wire logic  clear,
  piso_tx_if.slave   bus
);

  localparam int        CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam [7:0]      RELOAD = 8'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef PISO_TX_PARITY_EN
    PAR   = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  state_t           state_q;
  logic             so_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [7:0]       div_q;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
`endif

  logic bit_end;
  assign bit_end = (div_q == 8'd0);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      so_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      div_q    <= 8'd0;
`ifdef PISO_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Every bit state shares the divider; it reloads on each bit boundary.
      if (state_q != IDLE) begin
        div_q <= bit_end ? RELOAD : div_q - 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            shreg_q  <= bus.i;
`ifdef PISO_TX_PARITY_EN
            par_q    <= ^bus.i;
`endif
            bitcnt_q <= '0;
            div_q    <= RELOAD;
            so_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            so_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (bitcnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
              so_q    <= par_q;
              state_q <= PAR;
`else
              so_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bitcnt_q <= bitcnt_q + CNT_W'(1);
              so_q     <= shreg_q[1];
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        PAR: begin
          if (bit_end) begin
            so_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          so_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.so   = so_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_piso_tx : two serializers (BAUD_DIV 1 and 3) against a frame model   |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic         clk;
  logic         clear;
  logic         ld;
  logic [W-1:0] din;

  piso_tx_if #(.WIDTH(W)) bus1 ();
  piso_tx_if #(.WIDTH(W)) bus3 ();

  assign bus1.i    = din;
  assign bus1.load = ld;
  assign bus3.i    = din;
  assign bus3.load = ld;

  piso_tx #(.WIDTH(W), .BAUD_DIV(1)) u_dut1 (.clk(clk), .clear(clear), .bus(bus1));
  piso_tx #(.WIDTH(W), .BAUD_DIV(3)) u_dut3 (.clk(clk), .clear(clear), .bus(bus3));

  wire [1:0] so_v   = {bus3.so,   bus1.so};
  wire [1:0] busy_v = {bus3.busy, bus1.busy};
  wire [1:0] done_v = {bus3.done, bus1.done};

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: a frame is just its start cycle and captured word.
  int           st [2];
  logic [W-1:0] wd [2];
  bit           act [2];
  bit           pidle [2];
  int           bdv [2];

  task automatic chk(input string name, input int k, input logic actv, input logic expv);
    vectors++;
    if (actv !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, k, cyc, actv, expv);
    end
  endtask

  function automatic logic bitval(input logic [W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return w[idx-1];
`ifdef PISO_TX_PARITY_EN
    if (idx == W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic model_check();
    logic e_so, e_busy, e_done;
    int   t;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      e_so = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (!clear) begin
        act[k]   = 1'b0;
        pidle[k] = 1'b1;
      end else begin
        if (ld && pidle[k]) begin
          act[k] = 1'b1;
          st[k]  = cyc;
          wd[k]  = din;
        end
        if (act[k]) begin
          t = cyc - st[k];
          if (t < NB * bdv[k]) begin
            e_so   = bitval(wd[k], t / bdv[k]);
            e_busy = 1'b1;
          end else begin
            e_done = 1'b1;
            act[k] = 1'b0;
          end
        end
        pidle[k] = !e_busy;
      end
      chk("so",   k, so_v[k],   e_so);
      chk("busy", k, busy_v[k], e_busy);
      chk("done", k, done_v[k], e_done);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic l, input logic [W-1:0] d);
    ld  = l;
    din = d;
    @(posedge clk);
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic abort_frame();
    #2;
    clear = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      act[k]   = 1'b0;
      pidle[k] = 1'b1;
      chk("abort_so",   k, so_v[k],   1'b1);
      chk("abort_busy", k, busy_v[k], 1'b0);
      chk("abort_done", k, done_v[k], 1'b0);
    end
    @(negedge clk);
    step(1'b1, 4'b1111);
    clear = 1'b1;
  endtask

  logic [7:0]  lit_so, lit_busy, lit_done;
  logic [7:0]  rso, rbusy, rdone;
  logic [7:0]  lit3;
  logic [31:0] r3so, r3busy, r3done;
  int          nbusy, ndone;

  initial begin
    bdv[0] = 1; bdv[1] = 3;
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; pidle[k] = 1'b1; st[k] = 0; wd[k] = '0;
    end
    clear = 1'b1; ld = 1'b0; din = '0;

    // Reset pulse from t=2 to t=5, no load.
    #2 clear = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_so",   k, so_v[k],   1'b1);
      chk("rst_busy", k, busy_v[k], 1'b0);
      chk("rst_done", k, done_v[k], 1'b0);
    end
    #2 clear = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_so",   k, so_v[k],   1'b1);
      chk("post_rst_busy", k, busy_v[k], 1'b0);
      chk("post_rst_done", k, done_v[k], 1'b0);
    end

    // Hand-computed single frame on the BAUD_DIV=1 instance, bit j = cycle j.
`ifdef PISO_TX_PARITY_EN
    din = 4'b1011; lit_so = 8'b11110110; lit_busy = 8'b01111111; lit_done = 8'b10000000;
`else
    din = 4'b0011; lit_so = 8'b11100110; lit_busy = 8'b00111111; lit_done = 8'b01000000;
`endif
    step(1'b1, din);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step(1'b0, din);
      rso[j] = bus1.so; rbusy[j] = bus1.busy; rdone[j] = bus1.done;
    end
    for (int j = 0; j < 8; j++) begin
      chk("lit_so",   0, rso[j],   lit_so[j]);
      chk("lit_busy", 0, rbusy[j], lit_busy[j]);
      chk("lit_done", 0, rdone[j], lit_done[j]);
    end
    repeat (25) step(1'b0, 4'b0000);

    // Divided frame on the BAUD_DIV=3 instance with stray loads mid-frame.
`ifdef PISO_TX_PARITY_EN
    lit3 = 8'b01010100;
`else
    lit3 = 8'b00110100;
`endif
    step(1'b1, 4'b1010);
    for (int j = 0; j <= NB * 3; j++) begin
      if (j > 0) step((j % 5) == 2, 4'($urandom));
      r3so[j] = bus3.so; r3busy[j] = bus3.busy; r3done[j] = bus3.done;
    end
    nbusy = 0;
    for (int j = 0; j <= NB * 3; j++) nbusy += int'(r3busy[j]);
    vectors++;
    if (nbusy != NB * 3) begin
      miscompares++;
      $display("FAIL div_busy_len dut3: got %0d expected %0d", nbusy, NB * 3);
    end
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 3; r++)
        chk("div_hold", 1, r3so[3*b+r], lit3[b]);
    chk("div_done", 1, r3done[NB*3], 1'b1);
    repeat (25) step(1'b0, 4'b0000);

    // Back-to-back: load held high across the done cycle.
    ndone = 0;
    for (int j = 0; j < 16; j++) begin
      if (j == 0)      step(1'b1, 4'b0101);
      else if (j < 8)  step(1'b1, 4'b1100);
      else             step(1'b0, 4'b0000);
      ndone += int'(bus1.done);
      if (j == NB)     chk("b2b_done1",  0, bus1.done, 1'b1);
      if (j == NB + 1) chk("b2b_start2", 0, bus1.so,   1'b0);
    end
    vectors++;
    if (ndone != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count dut1: got %0d expected 2", ndone);
    end
    repeat (30) step(1'b0, 4'b0000);

    // Abort during the second data bit, then a clean frame.
    step(1'b1, 4'b0110);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    abort_frame();
    step(1'b1, 4'b0110);
    repeat (NB * 3 + 4) step(1'b0, 4'b0000);

    // Randomized traffic with occasional aborts.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) abort_frame();
      else step($urandom_range(0, 2) == 0, 4'($urandom));
    end
    repeat (NB * 3 + 2) step(1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
